boot_loader: RTL

Instruction-memory writer for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, packs the bytes into big-endian 32-bit words and writes them into the instruction memory's write port at consecutive word addresses. It holds the core in stall (`cpu_hold`) until the whole program is written. It sits between the external boot link and the instruction memory, beside the datapath's fetch path.

---
 rtl/boot_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot-time instruction-memory writer: unpacks a length-prefixed byte stream into
// big-endian words and writes them to consecutive word addresses while stalling the core.
module boot_loader #(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StFin,
        StDone,
        StErr
    } loadStateT;

    loadStateT   stateQ, stateD;
    logic [15:0] countQ, countD;
    logic [15:0] indexQ, indexD;
    logic [1:0]  byteCntQ, byteCntD;
    logic [23:0] shiftQ, shiftD;
    logic        memWeQ, memWeD;
    logic [31:0] memAdrQ, memAdrD;
    logic [31:0] memWdataQ, memWdataD;

    logic        accept;
    logic [15:0] lenFull;
    logic [31:0] lenWide;
    logic [15:0] nextIndex;

    assign byte_ready = (stateQ == StLen) || (stateQ == StData);
    assign accept     = byte_valid & byte_ready;
    assign lenFull    = {countQ[15:8], byte_in};
    assign lenWide    = {16'h0000, lenFull};
    assign nextIndex  = indexQ + 16'd1;

    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        indexD    = indexQ;
        byteCntD  = byteCntQ;
        shiftD    = shiftQ;
        memWeD    = 1'b0;
        memAdrD   = memAdrQ;
        memWdataD = memWdataQ;

        case (stateQ)
            StIdle, StDone, StErr: begin
                if (start) begin
                    stateD   = StLen;
                    countD   = 16'h0000;
                    indexD   = 16'h0000;
                    byteCntD = 2'd0;
                    shiftD   = 24'h00_0000;
                end
            end
            StLen: begin
                if (accept) begin
                    // byteCntQ[0] tracks which half of the count is arriving
                    if (byteCntQ == 2'd0) begin
                        countD[15:8] = byte_in;
                        byteCntD     = 2'd1;
                    end else begin
                        countD   = lenFull;
                        byteCntD = 2'd0;
                        if (lenFull == 16'h0000) begin
                            stateD = StDone;
                        end else if (lenWide > DEPTH) begin
                            stateD = StErr;
                        end else begin
                            stateD = StData;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (byteCntQ == 2'd3) begin
                        memWeD    = 1'b1;
                        memAdrD   = BASE + {14'h0000, indexQ, 2'b00};
                        memWdataD = {shiftQ, byte_in};
                        indexD    = nextIndex;
                        byteCntD  = 2'd0;
                        shiftD    = 24'h00_0000;
                        if (nextIndex == countQ) begin
                            stateD = StFin;
                        end
                    end else begin
                        shiftD   = {shiftQ[15:0], byte_in};
                        byteCntD = byteCntQ + 2'd1;
                    end
                end
            end
            StFin: begin
                stateD = StDone;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            countQ    <= 16'h0000;
            indexQ    <= 16'h0000;
            byteCntQ  <= 2'd0;
            shiftQ    <= 24'h00_0000;
            memWeQ    <= 1'b0;
            memAdrQ   <= BASE;
            memWdataQ <= 32'h0000_0000;
        end else begin
            stateQ    <= stateD;
            countQ    <= countD;
            indexQ    <= indexD;
            byteCntQ  <= byteCntD;
            shiftQ    <= shiftD;
            memWeQ    <= memWeD;
            memAdrQ   <= memAdrD;
            memWdataQ <= memWdataD;
        end
    end

    assign mem_we    = memWeQ;
    assign mem_adr   = memAdrQ;
    assign mem_wdata = memWdataQ;
    // The core only runs once a load has completed cleanly.
    assign cpu_hold  = (stateQ != StDone);
    assign done      = (stateQ == StDone);
    assign err       = (stateQ == StErr);

endmodule
